// File: rtl/ttl_pkg.sv
// Shared constants and types for the 7400 quad-NAND glue-logic block.
// Optional build macro used by this slice: TTL_7400_TOGGLE_CNT_EN
// (compiles in the per-gate output-transition counters).
package ttl_pkg;

  // Default width of each per-gate transition counter.
  localparam int CNT_W_DFLT = 16;

  // Value held in the sampled-output register out of reset.
  localparam logic Y_Q_RST = 1'b1;

  // Counter type at the default width.
  typedef logic [CNT_W_DFLT-1:0] tog_cnt_t;

endpackage

// File: rtl/ttl_7400_gate.sv
// One 2-input NAND gate plus its optional saturating output-transition counter.
// Ports: a, b -> y (combinational NAND); clk/rst_n/cnt_clr drive the counter,
//   and tog_cnt reports the count.
// Macro TTL_7400_TOGGLE_CNT_EN: when undefined, no flops exist and tog_cnt is 0.
module ttl_7400_gate
  import ttl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] tog_cnt
);

  // The gate never depends on clock, reset or clear.
  assign y = ~(a & b);

`ifdef TTL_7400_TOGGLE_CNT_EN

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic y_q;    // y as sampled on the previous edge
  logic valid;  // y_q holds a real sample taken since reset/clear

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_cnt <= '0;
      valid   <= 1'b0;
      y_q     <= Y_Q_RST;
    end else begin
      // y_q always follows y so the edge after a clear primes from a fresh sample.
      y_q <= y;
      if (cnt_clr) begin
        tog_cnt <= '0;
        valid   <= 1'b0;
      end else begin
        valid <= 1'b1;
        // An unknown y makes the compare unknown, so the increment is skipped.
        if (valid && (y != y_q) && (tog_cnt != CNT_MAX)) begin
          tog_cnt <= tog_cnt + 1'b1;
        end
      end
    end
  end

`else

  assign tog_cnt = '0;

  // Counter inputs have no function in this build.
  logic unused_ok;
  assign unused_ok = ^{clk, rst_n, cnt_clr};

`endif

endmodule

// File: rtl/ttl_7400.sv
// Quad 2-input NAND (7400 equivalent) with optional per-gate transition counters.
// Ports: A1..A4/B1..B4 -> Y1..Y4 (combinational); clk, rst_n (async active-low),
//   cnt_clr (sync clear) -> tog_cnt1..tog_cnt4. Macro: TTL_7400_TOGGLE_CNT_EN.
module ttl_7400
  import ttl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A1,
  input  logic             B1,
  input  logic             A2,
  input  logic             B2,
  input  logic             A3,
  input  logic             B3,
  input  logic             A4,
  input  logic             B4,
  input  logic             cnt_clr,
  output logic             Y1,
  output logic             Y2,
  output logic             Y3,
  output logic             Y4,
  output logic [CNT_W-1:0] tog_cnt1,
  output logic [CNT_W-1:0] tog_cnt2,
  output logic [CNT_W-1:0] tog_cnt3,
  output logic [CNT_W-1:0] tog_cnt4
);

  ttl_7400_gate #(.CNT_W(CNT_W)) u_gate1 (
    .clk(clk), .rst_n(rst_n), .a(A1), .b(B1), .cnt_clr(cnt_clr),
    .y(Y1), .tog_cnt(tog_cnt1)
  );

  ttl_7400_gate #(.CNT_W(CNT_W)) u_gate2 (
    .clk(clk), .rst_n(rst_n), .a(A2), .b(B2), .cnt_clr(cnt_clr),
    .y(Y2), .tog_cnt(tog_cnt2)
  );

  ttl_7400_gate #(.CNT_W(CNT_W)) u_gate3 (
    .clk(clk), .rst_n(rst_n), .a(A3), .b(B3), .cnt_clr(cnt_clr),
    .y(Y3), .tog_cnt(tog_cnt3)
  );

  ttl_7400_gate #(.CNT_W(CNT_W)) u_gate4 (
    .clk(clk), .rst_n(rst_n), .a(A4), .b(B4), .cnt_clr(cnt_clr),
    .y(Y4), .tog_cnt(tog_cnt4)
  );

endmodule

// File: tb/tb_ttl_7400.sv
// Self-checking bench for ttl_7400: truth tables, reset/stopped-clock behaviour,
// transition counting, clear priority, saturation and a randomized phase.
// Counter expectations come from a per-gate history of sampled outputs.
module tb_ttl_7400;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef TTL_7400_TOGGLE_CNT_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic             clk;
  logic             clk_en;
  logic             rst_n;
  logic             cnt_clr;
  logic             a [4];
  logic             b [4];
  logic             y [4];
  logic [CNT_W-1:0] cnt [4];

  int tests;
  int fails;

  // Sampled output history per gate since the last reset/clear.
  bit hist [4][$];

  ttl_7400 #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .A1(a[0]), .B1(b[0]), .A2(a[1]), .B2(b[1]),
    .A3(a[2]), .B3(b[2]), .A4(a[3]), .B4(b[3]),
    .cnt_clr(cnt_clr),
    .Y1(y[0]), .Y2(y[1]), .Y3(y[2]), .Y4(y[3]),
    .tog_cnt1(cnt[0]), .tog_cnt2(cnt[1]), .tog_cnt3(cnt[2]), .tog_cnt4(cnt[3])
  );

  always #5 if (clk_en) clk = ~clk;

  function automatic logic nand_ref(input logic x, input logic z);
    return (x === 1'b1 && z === 1'b1) ? 1'b0 : 1'b1;
  endfunction

  // Number of adjacent differing samples, saturated; zero when the unit is absent.
  function automatic int exp_cnt(input int g);
    int n;
    n = 0;
    for (int i = 1; i < hist[g].size(); i++)
      if (hist[g][i] != hist[g][i-1]) n++;
    if (n > CMAX) n = CMAX;
    return EN ? n : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_y(input string tag, input int g);
    tests++;
    assert (y[g] === nand_ref(a[g], b[g]))
    else begin
      fails++;
      $error("FAIL %s: Y%0d observed %b expected %b", tag, g + 1, y[g], nand_ref(a[g], b[g]));
    end
  endtask

  // One rising edge: record what the DUT samples, then look 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      if (cnt_clr) hist[g].delete();
      else hist[g].push_back(nand_ref(a[g], b[g]));
    end
    #1;
  endtask

  task automatic reset_model();
    for (int g = 0; g < 4; g++) hist[g].delete();
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    clk     = 1'b0;
    clk_en  = 1'b0;
    rst_n   = 1'b0;
    cnt_clr = 1'b0;
    for (int g = 0; g < 4; g++) begin a[g] = 1'b0; b[g] = 1'b0; end
    reset_model();
    #16;

    // Reset state.
    for (int g = 0; g < 4; g++) chk($sformatf("reset_cnt%0d", g + 1), int'(cnt[g]), 0);

    // Truth table per gate, the other three held at 1,1 (Y=0).
    for (int g = 0; g < 4; g++) begin
      for (int o = 0; o < 4; o++) begin a[o] = 1'b1; b[o] = 1'b1; end
      for (int p = 0; p < 4; p++) begin
        a[g] = p[0];
        b[g] = p[1];
        #16;
        chk($sformatf("tt_g%0d_p%0d", g + 1, p), int'(y[g]), (p == 3) ? 0 : 1);
        for (int o = 0; o < 4; o++)
          if (o != g) chk($sformatf("held_g%0d_while_g%0d", o + 1, g + 1), int'(y[o]), 0);
      end
    end

    // Reset held, clock stopped: gate 3 still follows its inputs, counter stays 0.
    b[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[2] = i[0];
      #16;
      chk_y($sformatf("rst_held_y3_%0d", i), 2);
      chk($sformatf("rst_held_cnt3_%0d", i), int'(cnt[2]), 0);
    end

    // Counting: release reset, toggle A1 every 2 cycles, 10 changes.
    for (int g = 0; g < 4; g++) begin a[g] = 1'b0; b[g] = 1'b1; end
    #3;
    rst_n = 1'b1;
    reset_model();
    #3;
    clk_en = 1'b1;
    tick();
    chk("prime_cnt1", int'(cnt[0]), 0);
    for (int i = 0; i < 10; i++) begin
      a[0] = ~a[0];
      tick();
      tick();
    end
    chk("count10_cnt1", int'(cnt[0]), EN ? 10 : 0);
    for (int g = 1; g < 4; g++) chk($sformatf("count10_other%0d", g + 1), int'(cnt[g]), 0);
    for (int g = 0; g < 4; g++) chk_y($sformatf("count10_y%0d", g + 1), g);

    // Clear coinciding with a Y2 transition, then a priming edge.
    for (int i = 0; i < 2; i++) begin a[1] = ~a[1]; tick(); end
    chk("pre_clr_cnt2", int'(cnt[1]), EN ? 2 : 0);
    a[1] = ~a[1];
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt2", int'(cnt[1]), 0);
    chk("clr_cnt1", int'(cnt[0]), 0);
    a[1] = ~a[1];
    tick();
    chk("prime_after_clr_cnt2", int'(cnt[1]), 0);
    a[1] = ~a[1];
    tick();
    chk("count_after_prime_cnt2", int'(cnt[1]), EN ? 1 : 0);

    // Saturation: 20 transitions on Y4.
    for (int i = 0; i < 20; i++) begin a[3] = ~a[3]; tick(); end
    chk("sat_cnt4", int'(cnt[3]), EN ? CMAX : 0);
    chk("sat_model_cnt4", int'(cnt[3]), exp_cnt(3));

    // Reset asserted mid-operation clears immediately, without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) chk($sformatf("midrst_cnt%0d", g + 1), int'(cnt[g]), 0);
    reset_model();
    #1;
    rst_n = 1'b1;

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 300; i++) begin
      for (int g = 0; g < 4; g++) begin
        a[g] = 1'($urandom_range(0, 1));
        b[g] = 1'($urandom_range(0, 1));
      end
      cnt_clr = ($urandom_range(0, 24) == 0);
      #1;
      for (int g = 0; g < 4; g++) chk_y($sformatf("rnd%0d_y%0d", i, g + 1), g);
      tick();
      cnt_clr = 1'b0;
      for (int g = 0; g < 4; g++)
        chk($sformatf("rnd%0d_cnt%0d", i, g + 1), int'(cnt[g]), exp_cnt(g));
    end

    clk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
